// File: rtl/icd_pkg.sv
// rtl/icd_pkg.sv - shared task ICD constants, framer state type and length check
package icd_pkg;

    localparam int HEADER_BYTES  = 12;
    localparam int MAX_MSG_BYTES = 64;
    localparam int MAX_MSG_WORDS = MAX_MSG_BYTES / 4;
    localparam int LEN_IDX       = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BODY    = 2'd1,
        DISCARD = 2'd2,
        FLUSH   = 2'd3
    } framer_state_t;

    // A length word is legal when word aligned and within [min_b, max_b] bytes.
    function automatic logic len_is_legal(input logic [31:0] len,
                                          input int          min_b,
                                          input int          max_b);
        return (len[1:0] == 2'b00) &&
               (len >= $unsigned(min_b)) &&
               (len <= $unsigned(max_b));
    endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte accumulator with one-word output register
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_byte_ready,
    input  logic        i_hold,
    input  logic        i_load,
    input  logic        i_load_sop,
    input  logic        i_load_eop,
    input  logic        i_flush,
    input  logic        i_clear,
    output logic        o_accept,
    output logic        o_word_done,
    output logic [31:0] o_word,
    output logic        o_partial,
    output logic        o_out_free,
    input  logic        i_out_ready,
    output logic        o_out_valid,
    output logic        o_out_sop,
    output logic        o_out_eop,
    output logic [31:0] o_out_data
);

    logic [23:0] r_acc;
    logic [1:0]  r_idx;
    logic        r_out_valid;
    logic        r_out_sop;
    logic        r_out_eop;
    logic [31:0] r_out_data;
    logic        w_stall;

    // A word-completing byte must wait if the output register cannot take it.
    assign w_stall      = (r_idx == 2'd3) && r_out_valid && !i_out_ready;
    assign o_byte_ready = rst_n && !i_hold && !w_stall;
    assign o_accept     = i_byte_valid && o_byte_ready;
    assign o_word_done  = o_accept && (r_idx == 2'd3);
    assign o_word       = {i_byte_data, r_acc};
    assign o_partial    = (r_idx != 2'd0);
    assign o_out_free   = !r_out_valid || i_out_ready;

    // Upper accumulator bytes are always zero beyond the index, so a flush is zero-filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (i_flush || i_clear) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (o_accept) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
                2'd0:    r_acc[7:0]   <= i_byte_data;
                2'd1:    r_acc[15:8]  <= i_byte_data;
                2'd2:    r_acc[23:16] <= i_byte_data;
                default: r_acc        <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_data  <= '0;
        end else if (i_load) begin
            r_out_valid <= 1'b1;
            r_out_sop   <= i_load_sop;
            r_out_eop   <= i_load_eop;
            r_out_data  <= o_word;
        end else if (i_flush) begin
            r_out_valid <= 1'b1;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b1;
            r_out_data  <= {8'h00, r_acc};
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_sop   = r_out_sop;
    assign o_out_eop   = r_out_eop;
    assign o_out_data  = r_out_data;

endmodule

// File: rtl/task_framer.sv
// rtl/task_framer.sv - frames a raw byte stream into length-delimited 32-bit task packets
module task_framer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int HEADER_BYTES   = icd_pkg::HEADER_BYTES,
    parameter int MAX_MSG_BYTES  = icd_pkg::MAX_MSG_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        asi_byte_ready,
    input  logic        asi_byte_valid,
    input  logic [7:0]  asi_byte_data,
    input  logic        aso_task_ready,
    output logic        aso_task_valid,
    output logic        aso_task_sop,
    output logic        aso_task_eop,
    output logic [31:0] aso_task_data,
    output logic        err_len,
    output logic        err_timeout
);

    import icd_pkg::*;

    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WL_W = $clog2(MAX_MSG_BYTES / 4 + 1);

    framer_state_t   r_state;
    framer_state_t   w_state_nxt;
    logic [WL_W-1:0] r_words_left;
    logic [WL_W-1:0] w_words_left_nxt;
    logic [TW-1:0]   r_tcnt;
    logic [TW-1:0]   w_tcnt_nxt;
    logic            r_err_len;
    logic            r_err_timeout;

    logic            w_accept;
    logic            w_word_done;
    logic            w_partial;
    logic            w_out_free;
    logic [31:0]     w_word;
    logic            w_hold;
    logic            w_load;
    logic            w_load_sop;
    logic            w_load_eop;
    logic            w_flush;
    logic            w_clear;
    logic            w_err_len;
    logic            w_err_timeout;
    logic            w_counting;
    logic            w_timeout;

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_byte_valid (asi_byte_valid),
        .i_byte_data  (asi_byte_data),
        .o_byte_ready (asi_byte_ready),
        .i_hold       (w_hold),
        .i_load       (w_load),
        .i_load_sop   (w_load_sop),
        .i_load_eop   (w_load_eop),
        .i_flush      (w_flush),
        .i_clear      (w_clear),
        .o_accept     (w_accept),
        .o_word_done  (w_word_done),
        .o_word       (w_word),
        .o_partial    (w_partial),
        .o_out_free   (w_out_free),
        .i_out_ready  (aso_task_ready),
        .o_out_valid  (aso_task_valid),
        .o_out_sop    (aso_task_sop),
        .o_out_eop    (aso_task_eop),
        .o_out_data   (aso_task_data)
    );

    assign w_hold     = (r_state == FLUSH);
    assign w_counting = (r_state == BODY) || (r_state == DISCARD) ||
                        ((r_state == IDLE) && w_partial);
    // A byte accepted on the saturation cycle wins over the timeout.
    assign w_timeout  = w_counting && !w_accept && (r_tcnt == TW'(TIMEOUT_CYCLES));

    always_comb begin
        w_tcnt_nxt = r_tcnt;
        if (w_accept || !w_counting || w_timeout) begin
            w_tcnt_nxt = '0;
        end else if (r_tcnt != TW'(TIMEOUT_CYCLES)) begin
            w_tcnt_nxt = r_tcnt + TW'(1);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_words_left_nxt = r_words_left;
        w_load           = 1'b0;
        w_load_sop       = 1'b0;
        w_load_eop       = 1'b0;
        w_flush          = 1'b0;
        w_clear          = 1'b0;
        w_err_len        = 1'b0;
        w_err_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_word_done) begin
                    if (len_is_legal(w_word, HEADER_BYTES, MAX_MSG_BYTES)) begin
                        w_load           = 1'b1;
                        w_load_sop       = 1'b1;
                        w_words_left_nxt = w_word[WL_W+1:2] - WL_W'(1);
                        w_state_nxt      = BODY;
                    end else begin
                        w_err_len   = 1'b1;
                        w_state_nxt = DISCARD;
                    end
                end else if (w_timeout) begin
                    w_clear       = 1'b1;
                    w_err_timeout = 1'b1;
                end
            end
            BODY: begin
                if (w_word_done) begin
                    w_load           = 1'b1;
                    w_load_eop       = (r_words_left == WL_W'(1));
                    w_words_left_nxt = r_words_left - WL_W'(1);
                    if (r_words_left == WL_W'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = FLUSH;
                end
            end
            DISCARD: begin
                if (w_timeout) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (w_out_free) begin
                    w_flush       = 1'b1;
                    w_err_timeout = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_words_left  <= '0;
            r_tcnt        <= '0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_words_left  <= w_words_left_nxt;
            r_tcnt        <= w_tcnt_nxt;
            r_err_len     <= w_err_len;
            r_err_timeout <= w_err_timeout;
        end
    end

    assign err_len     = r_err_len;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_task_framer.sv
// tb/tb_task_framer.sv - directed self-checking bench for task_framer with a byte-queue reference model
module tb_task_framer;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        asi_byte_ready;
    logic        asi_byte_valid = 1'b0;
    logic [7:0]  asi_byte_data = 8'h00;
    logic        aso_task_ready = 1'b1;
    logic        aso_task_valid;
    logic        aso_task_sop;
    logic        aso_task_eop;
    logic [31:0] aso_task_data;
    logic        err_len;
    logic        err_timeout;

    always #5 clk = ~clk;

    task_framer #(
        .TIMEOUT_CYCLES (T),
        .HEADER_BYTES   (12),
        .MAX_MSG_BYTES  (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .asi_byte_ready (asi_byte_ready),
        .asi_byte_valid (asi_byte_valid),
        .asi_byte_data  (asi_byte_data),
        .aso_task_ready (aso_task_ready),
        .aso_task_valid (aso_task_valid),
        .aso_task_sop   (aso_task_sop),
        .aso_task_eop   (aso_task_eop),
        .aso_task_data  (aso_task_data),
        .err_len        (err_len),
        .err_timeout    (err_timeout)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_el = 0;
    int n_et = 0;
    int n_stall = 0;
    bit chk_on = 1'b0;
    logic [33:0] log_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [33:0] exp);
        if (idx < log_q.size()) begin
            chk(name, {30'd0, log_q[idx]}, {30'd0, exp});
        end else begin
            n_chk++;
            n_err++;
            $display("FAIL %s: got no word expected %0h", name, exp);
        end
    endtask

    // Reference model: byte queue plus the framing rules, one update per clock.
    int          m_st = 0;
    logic [7:0]  m_q[$];
    int          m_wl = 0;
    int          m_idle = 0;
    bit          m_ov = 0;
    bit          m_sop = 0;
    bit          m_eop = 0;
    bit          m_el = 0;
    bit          m_et = 0;
    logic [31:0] m_od = 32'h0;

    function automatic bit m_ready();
        if (!rst_n) return 1'b0;
        if (m_st == 3) return 1'b0;
        if (m_q.size() == 3 && m_ov && !aso_task_ready) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_q.delete(); m_wl = 0; m_idle = 0;
            m_ov = 0; m_sop = 0; m_eop = 0; m_el = 0; m_et = 0; m_od = 32'h0;
        end else begin
            bit acc;
            bit free;
            bit counting;
            bit tmo;
            logic [31:0] w;
            acc      = asi_byte_valid && m_ready();
            free     = !m_ov || aso_task_ready;
            counting = (m_st == 1) || (m_st == 2) || (m_st == 0 && m_q.size() != 0);
            tmo      = counting && !acc && (m_idle == T);
            m_el = 0;
            m_et = 0;
            if (m_ov && aso_task_ready) m_ov = 0;
            if (acc) begin
                m_q.push_back(asi_byte_data);
                if (m_q.size() == 4) begin
                    w = {m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_q.delete();
                    if (m_st == 0) begin
                        if (w % 4 == 0 && w >= 12 && w <= 64) begin
                            m_ov = 1; m_od = w; m_sop = 1; m_eop = 0;
                            m_wl = w / 4 - 1; m_st = 1;
                        end else begin
                            m_el = 1; m_st = 2;
                        end
                    end else if (m_st == 1) begin
                        m_ov = 1; m_od = w; m_sop = 0; m_eop = (m_wl == 1);
                        m_wl--;
                        if (m_wl == 0) m_st = 0;
                    end
                end
            end else if (tmo) begin
                if (m_st == 0) begin
                    m_q.delete(); m_et = 1;
                end else if (m_st == 1) begin
                    m_st = 3;
                end else if (m_st == 2) begin
                    m_q.delete(); m_st = 0;
                end
            end else if (m_st == 3 && free) begin
                w = 32'h0;
                foreach (m_q[i]) w[i*8 +: 8] = m_q[i];
                m_ov = 1; m_od = w; m_sop = 0; m_eop = 1;
                m_q.delete(); m_et = 1; m_st = 0;
            end
            if (acc || !counting || tmo) m_idle = 0;
            else if (m_idle < T) m_idle++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("byte_ready", {63'd0, asi_byte_ready}, {63'd0, m_ready()});
            chk("task_valid", {63'd0, aso_task_valid}, {63'd0, m_ov});
            if (m_ov) begin
                chk("task_data", {32'd0, aso_task_data}, {32'd0, m_od});
                chk("task_sop", {63'd0, aso_task_sop}, {63'd0, m_sop});
                chk("task_eop", {63'd0, aso_task_eop}, {63'd0, m_eop});
            end
            chk("err_len", {63'd0, err_len}, {63'd0, m_el});
            chk("err_timeout", {63'd0, err_timeout}, {63'd0, m_et});
        end
        if (aso_task_valid && aso_task_ready) log_q.push_back({aso_task_sop, aso_task_eop, aso_task_data});
        if (err_len) n_el++;
        if (err_timeout) n_et++;
        if (asi_byte_valid && !asi_byte_ready) n_stall++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        int n;
        n = 0;
        asi_byte_valid = 1'b1;
        asi_byte_data  = b;
        forever begin
            @(negedge clk);
            got = asi_byte_ready;
            @(posedge clk);
            #1;
            if (got) break;
            n++;
            if (n > 200) begin
                n_chk++;
                n_err++;
                $display("FAIL send_byte_timeout: got no accept expected accept of %0h", b);
                break;
            end
        end
        asi_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
    endtask

    initial begin
        int base;
        int el0;
        int et0;
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, aso_task_valid}, 64'd0);
        chk("rst_ready", {63'd0, asi_byte_ready}, 64'd0);
        chk("rst_data", {32'd0, aso_task_data}, 64'd0);
        rst_n = 1'b1;
        idle(1);

        // Legal 12-byte task with per-word latency
        base = log_q.size();
        send_word(32'h0000000C);
        chk("lat_w0_valid", {63'd0, aso_task_valid}, 64'd1);
        chk("lat_w0_data", {32'd0, aso_task_data}, 64'h0C);
        send_word(32'h00000001);
        send_word(32'h00000000);
        idle(3);
        chk("t1_words", log_q.size() - base, 3);
        chk_log("t1_w0", base + 0, 34'h2_0000000C);
        chk_log("t1_w1", base + 1, 34'h0_00000001);
        chk_log("t1_w2", base + 2, 34'h1_00000000);
        chk("t1_errs", n_el + n_et, 0);

        // Backpressure on a 16-byte task
        base = log_q.size();
        n_stall = 0;
        fork
            begin
                send_word(32'h00000010);
                send_word(32'h04030201);
                send_word(32'h08070605);
                send_word(32'h0C0B0A09);
            end
            begin
                int k;
                k = 0;
                while (!(aso_task_valid && aso_task_sop) && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                if (k >= 100) chk("bp_sop_seen", 64'd0, 64'd1);
                @(posedge clk);
                #1;
                aso_task_ready = 1'b0;
                idle(10);
                aso_task_ready = 1'b1;
            end
        join
        idle(3);
        chk("bp_stalled", {63'd0, n_stall > 0}, 64'd1);
        chk_log("bp_w0", base + 0, 34'h2_00000010);
        chk_log("bp_w1", base + 1, 34'h0_04030201);
        chk_log("bp_w2", base + 2, 34'h0_08070605);
        chk_log("bp_w3", base + 3, 34'h1_0C0B0A09);
        chk("bp_words", log_q.size() - base, 4);

        // Illegal lengths, then a legal task after the discard timeout
        base = log_q.size();
        el0 = n_el;
        send_word(32'h0000000D);
        idle(T + 3);
        send_word(32'h00000008);
        idle(T + 3);
        send_word(32'h00000044);
        idle(T + 3);
        chk("il_err_len", n_el - el0, 3);
        chk("il_no_words", log_q.size() - base, 0);
        send_word(32'h0000000C);
        send_word(32'hA1B2C3D4);
        send_word(32'h55667788);
        idle(3);
        chk_log("il_w0", base + 0, 34'h2_0000000C);
        chk_log("il_w1", base + 1, 34'h0_A1B2C3D4);
        chk_log("il_w2", base + 2, 34'h1_55667788);

        // Truncated frame flushed on timeout
        base = log_q.size();
        et0 = n_et;
        send_word(32'h00000010);
        send_word(32'h44332211);
        send_byte(8'h55);
        send_byte(8'h66);
        idle(T + 5);
        chk_log("tr_w0", base + 0, 34'h2_00000010);
        chk_log("tr_w1", base + 1, 34'h0_44332211);
        chk_log("tr_w2", base + 2, 34'h1_00006655);
        chk("tr_err_to", n_et - et0, 1);

        // Byte arriving on the exact timeout cycle keeps the frame alive
        base = log_q.size();
        et0 = n_et;
        send_word(32'h00000010);
        send_word(32'h04030201);
        idle(T);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h08);
        send_word(32'h0C0B0A09);
        idle(3);
        chk_log("ex_w2", base + 2, 34'h0_08070605);
        chk_log("ex_w3", base + 3, 34'h1_0C0B0A09);
        chk("ex_no_err_to", n_et - et0, 0);

        // Timeout with the output stalled: flush waits for ready
        base = log_q.size();
        et0 = n_et;
        aso_task_ready = 1'b0;
        send_word(32'h00000010);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        idle(T + 8);
        chk("st_flush_ready", {63'd0, asi_byte_ready}, 64'd0);
        chk("st_no_err_yet", n_et - et0, 0);
        aso_task_ready = 1'b1;
        idle(4);
        chk_log("st_w0", base + 0, 34'h2_00000010);
        chk_log("st_w1", base + 1, 34'h1_00CCBBAA);
        chk("st_err_to", n_et - et0, 1);

        // Reset asserted mid-BODY
        aso_task_ready = 1'b0;
        send_word(32'h00000010);
        send_byte(8'h01);
        send_byte(8'h02);
        chk("mr_pre_valid", {63'd0, aso_task_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", {63'd0, aso_task_valid}, 64'd0);
        chk("mr_sop", {63'd0, aso_task_sop}, 64'd0);
        chk("mr_data", {32'd0, aso_task_data}, 64'd0);
        chk("mr_ready", {63'd0, asi_byte_ready}, 64'd0);
        idle(2);
        rst_n = 1'b1;
        aso_task_ready = 1'b1;
        base = log_q.size();
        send_word(32'h0000000C);
        send_word(32'hDEADBEEF);
        send_word(32'h12345678);
        idle(3);
        chk("mr_words", log_q.size() - base, 3);
        chk_log("mr_w0", base + 0, 34'h2_0000000C);
        chk_log("mr_w1", base + 1, 34'h0_DEADBEEF);
        chk_log("mr_w2", base + 2, 34'h1_12345678);

        idle(2);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
